// File: rtl/aes_decrypt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_decrypt_ctrl
// Brief    : Round sequencer for an AES-128 decryption datapath. Holds the
//            128-bit state register, walks the inverse-cipher round FSM and
//            steers the state through the external InvShiftRows,
//            InvSubBytes (registered ROM), AddRoundKey and 32-bit
//            InvMixColumns units.
// Options  : AES_CTRL_PERF_EN - adds a saturating busy-cycle counter
//            output cyc_count[15:0].
// Revision : 1.0 - initial release
// ============================================================================
module aes_decrypt_ctrl #(
    parameter int SB_WAIT = 2          // ISB dwell in cycles (1..3)
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         AES_START,
    input  logic         KEY_VALID,
    input  logic [127:0] AES_MSG_ENC,
    input  logic [127:0] isr_out,
    input  logic [127:0] isb_out,
    input  logic [127:0] ark_out,
    input  logic [31:0]  imc_out,
    output logic [127:0] state_q,
    output logic [4:0]   ark_round,
    output logic [31:0]  imc_in,
    output logic [1:0]   imc_word_sel,
    output logic [127:0] AES_MSG_DEC,
    output logic         AES_DONE,
    output logic         busy
`ifdef AES_CTRL_PERF_EN
    ,
    output logic [15:0]  cyc_count
`endif
);

    // Value of the ISB wait counter on the cycle the ROM output is captured
    localparam logic [1:0] c_SB_LAST = 2'(SB_WAIT - 1);

    typedef enum logic [2:0] {
        S_WAIT     = 3'd0,
        S_LOAD     = 3'd1,
        S_INIT_ARK = 3'd2,
        S_ISR      = 3'd3,
        S_ISB      = 3'd4,
        S_ARK      = 3'd5,
        S_IMC      = 3'd6,
        S_DONE     = 3'd7
    } fsm_e;

    fsm_e         fsm_q;
    logic [3:0]   rnd_q;
    logic [1:0]   sb_cnt_q;
    logic [127:0] imc_merge_d;

    // Select the state column presented to InvMixColumns
    always_comb begin
        imc_in = state_q[127:96];
        case (imc_word_sel)
            2'd0: imc_in = state_q[127:96];
            2'd1: imc_in = state_q[95:64];
            2'd2: imc_in = state_q[63:32];
            2'd3: imc_in = state_q[31:0];
            default: imc_in = state_q[127:96];
        endcase
    end

    // State with the currently selected column replaced by the IMC result
    always_comb begin
        imc_merge_d = state_q;
        case (imc_word_sel)
            2'd0: imc_merge_d[127:96] = imc_out;
            2'd1: imc_merge_d[95:64]  = imc_out;
            2'd2: imc_merge_d[63:32]  = imc_out;
            2'd3: imc_merge_d[31:0]   = imc_out;
            default: imc_merge_d = state_q;
        endcase
    end

    // Round FSM; every output is registered and updated on the entering edge
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fsm_q        <= S_WAIT;
            state_q      <= '0;
            AES_MSG_DEC  <= '0;
            ark_round    <= '0;
            imc_word_sel <= '0;
            rnd_q        <= '0;
            sb_cnt_q     <= '0;
            AES_DONE     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (fsm_q)
                S_WAIT: begin
                    if (AES_START && KEY_VALID) begin
                        fsm_q <= S_LOAD;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state_q   <= AES_MSG_ENC;
                    rnd_q     <= 4'd10;
                    // INIT_ARK needs the last round key on its first cycle
                    ark_round <= 5'd10;
                    fsm_q     <= S_INIT_ARK;
                end
                S_INIT_ARK: begin
                    state_q <= ark_out;
                    rnd_q   <= 4'd9;
                    fsm_q   <= S_ISR;
                end
                S_ISR: begin
                    state_q  <= isr_out;
                    sb_cnt_q <= '0;
                    fsm_q    <= S_ISB;
                end
                S_ISB: begin
                    // State is held so the ROM sees a stable address
                    if (sb_cnt_q == c_SB_LAST) begin
                        state_q   <= isb_out;
                        ark_round <= {1'b0, rnd_q};
                        fsm_q     <= S_ARK;
                    end else begin
                        sb_cnt_q <= sb_cnt_q + 2'd1;
                    end
                end
                S_ARK: begin
                    state_q <= ark_out;
                    if (rnd_q == 4'd0) begin
                        fsm_q       <= S_DONE;
                        busy        <= 1'b0;
                        AES_DONE    <= 1'b1;
                        AES_MSG_DEC <= ark_out;
                    end else begin
                        imc_word_sel <= 2'd0;
                        fsm_q        <= S_IMC;
                    end
                end
                S_IMC: begin
                    state_q      <= imc_merge_d;
                    imc_word_sel <= imc_word_sel + 2'd1;
                    if (imc_word_sel == 2'd3) begin
                        rnd_q <= rnd_q - 4'd1;
                        fsm_q <= S_ISR;
                    end
                end
                S_DONE: begin
                    // A level START must drop before another run can begin
                    if (!AES_START) begin
                        fsm_q       <= S_WAIT;
                        AES_DONE    <= 1'b0;
                        AES_MSG_DEC <= '0;
                    end
                end
                default: begin
                    fsm_q       <= S_WAIT;
                    busy        <= 1'b0;
                    AES_DONE    <= 1'b0;
                    AES_MSG_DEC <= '0;
                end
            endcase
        end
    end

`ifdef AES_CTRL_PERF_EN
    // Busy-cycle counter: cleared in LOAD, saturating, frozen once idle
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cyc_count <= '0;
        end else if (fsm_q == S_LOAD) begin
            cyc_count <= '0;
        end else if (busy && (cyc_count != 16'hFFFF)) begin
            cyc_count <= cyc_count + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire
